// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI TMDS encoder.
//   CNT_W       : width of the signed running-disparity counter
//   CTL_00..11  : 10-bit control tokens sent during blanking, indexed {C1,C0}
//   CTL_NONE    : control pair for channels that carry no sync
//   n1_of()     : number of ones in an 8-bit value
package tmds_pkg;

  localparam int unsigned CNT_W = 6;

  localparam logic [9:0] CTL_00 = 10'h354;
  localparam logic [9:0] CTL_01 = 10'h0AB;
  localparam logic [9:0] CTL_10 = 10'h154;
  localparam logic [9:0] CTL_11 = 10'h2AB;

  localparam logic [1:0] CTL_NONE = 2'b00;

  function automatic logic [3:0] n1_of(input logic [7:0] d);
    logic [3:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      s = s + {3'b000, d[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// Single TMDS channel encoder: 3-stage pipeline, one 10-bit symbol per clock.
//   PixelClk : pixel clock, rising edge
//   RstB     : synchronous active-low reset
//   De       : 1 = encode D, 0 = send control token for C
//   C[1:0]   : control bits {C1,C0} used while De=0
//   D[7:0]   : pixel byte
//   Q[9:0]   : registered TMDS symbol, valid 3 edges after inputs are sampled
module tmds_channel_enc
  import tmds_pkg::*;
(
  input  logic       PixelClk,
  input  logic       RstB,
  input  logic       De,
  input  logic [1:0] C,
  input  logic [7:0] D,
  output logic [9:0] Q
);

  localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

  // Stage 1: captured inputs and their popcount
  logic [7:0] d1_q;
  logic       de1_q;
  logic [1:0] c1_q;
  logic [3:0] n1d1_q;

  // Stage 2: transition-minimised word and its ones/zeros balance
  logic [8:0] qm2_q, qm2_d;
  logic [3:0] n1_2_q, n1_2_d;
  logic [3:0] n0_2_q, n0_2_d;
  logic       de2_q;
  logic [1:0] c2_q;

  // Stage 3: output symbol and running disparity
  logic [9:0]              q3_q, q3_d;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge PixelClk) begin
    if (!RstB) begin
      d1_q   <= '0;
      de1_q  <= 1'b0;
      c1_q   <= '0;
      n1d1_q <= '0;
    end else begin
      d1_q   <= D;
      de1_q  <= De;
      c1_q   <= C;
      n1d1_q <= n1_of(D);
    end
  end

  // XNOR chain when the byte is ones-heavy (ties broken by D[0]); q_m[8]
  // records which chain was used so the decoder can undo it.
  always_comb begin
    logic       use_xnor;
    logic [8:0] qm_v;
    use_xnor = (n1d1_q > 4'd4) || ((n1d1_q == 4'd4) && !d1_q[0]);
    qm_v     = '0;
    qm_v[0]  = d1_q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      qm_v[i] = use_xnor ? ~(qm_v[i-1] ^ d1_q[i]) : (qm_v[i-1] ^ d1_q[i]);
    end
    qm_v[8] = ~use_xnor;
    qm2_d   = qm_v;
    n1_2_d  = n1_of(qm_v[7:0]);
    n0_2_d  = 4'd8 - n1_2_d;
  end

  always_ff @(posedge PixelClk) begin
    if (!RstB) begin
      qm2_q  <= '0;
      n1_2_q <= '0;
      n0_2_q <= '0;
      de2_q  <= 1'b0;
      c2_q   <= '0;
    end else begin
      qm2_q  <= qm2_d;
      n1_2_q <= n1_2_d;
      n0_2_q <= n0_2_d;
      de2_q  <= de1_q;
      c2_q   <= c1_q;
    end
  end

  // Pick inversion to steer the running disparity back towards zero.
  // The counter update equals the disparity of the emitted 10-bit symbol.
  always_comb begin
    logic signed [CNT_W-1:0] n1_s;
    logic signed [CNT_W-1:0] n0_s;
    logic signed [CNT_W-1:0] diff;
    logic                    q8;
    logic                    cnt_pos;
    logic                    cnt_neg;
    n1_s    = CNT_W'(n1_2_q);
    n0_s    = CNT_W'(n0_2_q);
    diff    = n1_s - n0_s;
    q8      = qm2_q[8];
    cnt_neg = cnt_q[CNT_W-1];
    cnt_pos = !cnt_neg && (cnt_q != '0);
    q3_d    = CTL_00;
    cnt_d   = cnt_q;
    if (!de2_q) begin
      cnt_d = '0;
      unique case (c2_q)
        2'b00:   q3_d = CTL_00;
        2'b01:   q3_d = CTL_01;
        2'b10:   q3_d = CTL_10;
        default: q3_d = CTL_11;
      endcase
    end else if ((cnt_q == '0) || (n1_2_q == n0_2_q)) begin
      q3_d  = {~q8, q8, (q8 ? qm2_q[7:0] : ~qm2_q[7:0])};
      cnt_d = q8 ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((cnt_pos && (n1_2_q > n0_2_q)) || (cnt_neg && (n0_2_q > n1_2_q))) begin
      q3_d  = {1'b1, q8, ~qm2_q[7:0]};
      cnt_d = cnt_q + (q8 ? TWO : '0) - diff;
    end else begin
      q3_d  = {1'b0, q8, qm2_q[7:0]};
      cnt_d = cnt_q - (q8 ? '0 : TWO) + diff;
    end
  end

  always_ff @(posedge PixelClk) begin
    if (!RstB) begin
      q3_q  <= CTL_00;
      cnt_q <= '0;
    end else begin
      q3_q  <= q3_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q = q3_q;

endmodule

// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder for the 720p timing generator output.
//   PixelClk : pixel clock, rising edge
//   RstB     : synchronous active-low reset
//   VideoDE  : 1 = active pixel, 0 = blanking
//   VideoHS  : horizontal sync, carried on blue C0
//   VideoVS  : vertical sync, carried on blue C1
//   VideoDin : pixel {R[23:16], G[15:8], B[7:0]}
//   TmdsCh0  : blue symbol
//   TmdsCh1  : green symbol
//   TmdsCh2  : red symbol
// Symbols appear 3 register stages after the inputs are sampled.
module dvi_tmds_encoder
  import tmds_pkg::*;
(
  input  logic        PixelClk,
  input  logic        RstB,
  input  logic        VideoDE,
  input  logic        VideoHS,
  input  logic        VideoVS,
  input  logic [23:0] VideoDin,
  output logic [9:0]  TmdsCh0,
  output logic [9:0]  TmdsCh1,
  output logic [9:0]  TmdsCh2
);

  tmds_channel_enc u_ch0_blue (
    .PixelClk (PixelClk),
    .RstB     (RstB),
    .De       (VideoDE),
    .C        ({VideoVS, VideoHS}),
    .D        (VideoDin[7:0]),
    .Q        (TmdsCh0)
  );

  tmds_channel_enc u_ch1_green (
    .PixelClk (PixelClk),
    .RstB     (RstB),
    .De       (VideoDE),
    .C        (CTL_NONE),
    .D        (VideoDin[15:8]),
    .Q        (TmdsCh1)
  );

  tmds_channel_enc u_ch2_red (
    .PixelClk (PixelClk),
    .RstB     (RstB),
    .De       (VideoDE),
    .C        (CTL_NONE),
    .D        (VideoDin[23:16]),
    .Q        (TmdsCh2)
  );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Scoreboard bench for dvi_tmds_encoder: stimulus pushes expected symbols,
// a negedge monitor pops and compares them 2 edges after the sampling edge.
module tb_dvi_tmds_encoder;

  logic        PixelClk = 1'b0;
  logic        RstB     = 1'b0;
  logic        VideoDE  = 1'b0;
  logic        VideoHS  = 1'b0;
  logic        VideoVS  = 1'b0;
  logic [23:0] VideoDin = '0;
  logic [9:0]  TmdsCh0, TmdsCh1, TmdsCh2;

  dvi_tmds_encoder dut (
    .PixelClk (PixelClk),
    .RstB     (RstB),
    .VideoDE  (VideoDE),
    .VideoHS  (VideoHS),
    .VideoVS  (VideoVS),
    .VideoDin (VideoDin),
    .TmdsCh0  (TmdsCh0),
    .TmdsCh1  (TmdsCh1),
    .TmdsCh2  (TmdsCh2)
  );

  always #5 PixelClk = ~PixelClk;

  typedef struct {
    int              cyc;
    bit              dec;
    bit [63:0]       tag;
    logic [2:0][9:0] exp;
    logic [2:0][7:0] dat;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;
  int   cnt_m [3];
  bit   stim_done = 0;

  always @(posedge PixelClk) edge_cnt <= edge_cnt + 1;

  function automatic logic [9:0] ref_enc(input logic [7:0] d, inout int cnt);
    int         ones;
    int         n1q;
    logic [8:0] qm;
    logic [9:0] sym;
    ones = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ~^ d[i];
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    if (cnt == 0 || n1q == 4) begin
      sym = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
    end else if ((cnt > 0 && n1q > 4) || (cnt < 0 && n1q < 4)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
    end
    cnt = cnt + 2 * $countones(sym) - 10;
    return sym;
  endfunction

  function automatic logic [7:0] dec10(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] token(input bit vs, input bit hs);
    case ({vs, hs})
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // One input cycle. hand=1 pushes the given hand-computed symbols instead of
  // the model's, while still advancing the model's disparity state.
  task automatic step(input bit rstb, input bit de, input bit hs, input bit vs,
                      input logic [23:0] din, input bit [63:0] tag,
                      input bit hand, input logic [9:0] h0, input logic [9:0] h1,
                      input logic [9:0] h2);
    exp_t e;
    exp_t t;
    @(posedge PixelClk);
    #1;
    RstB     = rstb;
    VideoDE  = de;
    VideoHS  = hs;
    VideoVS  = vs;
    VideoDin = din;
    e.cyc = edge_cnt + 1;
    e.tag = tag;
    e.dat = din;
    e.dec = 1'b0;
    if (!rstb) begin
      for (int c = 0; c < 3; c++) begin
        cnt_m[c] = 0;
        e.exp[c] = 10'h354;
      end
      // The two pixels still in flight are discarded by this reset.
      for (int j = 1; j <= 2; j++) begin
        if (sb.size() >= j) begin
          t = sb[sb.size()-j];
          t.exp = {3{10'h354}};
          t.dec = 1'b0;
          sb[sb.size()-j] = t;
        end
      end
    end else if (!de) begin
      for (int c = 0; c < 3; c++) cnt_m[c] = 0;
      e.exp[0] = token(vs, hs);
      e.exp[1] = 10'h354;
      e.exp[2] = 10'h354;
    end else begin
      e.dec = 1'b1;
      for (int c = 0; c < 3; c++) e.exp[c] = ref_enc(din[c*8 +: 8], cnt_m[c]);
    end
    if (hand) begin
      e.exp[0] = h0;
      e.exp[1] = h1;
      e.exp[2] = h2;
    end
    sb.push_back(e);
  endtask

  task automatic go(input bit rstb, input bit de, input bit hs, input bit vs,
                    input logic [23:0] din, input bit [63:0] tag);
    step(rstb, de, hs, vs, din, tag, 1'b0, '0, '0, '0);
  endtask

  task automatic check(input bit [63:0] tag, input string what, input int ch,
                       input logic [9:0] act, input logic [9:0] req, input int cyc);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %0s %0s ch%0d actual=%h required=%h cyc=%0d", tag, what, ch, act, req, cyc);
    end
  endtask

  // Monitor: the DUT presents a symbol every clock; compare the one whose
  // inputs were sampled two edges before the most recent edge.
  int rd [3] = '{0, 0, 0};
  always @(negedge PixelClk) begin
    exp_t e;
    logic [9:0] act [3];
    act[0] = TmdsCh0;
    act[1] = TmdsCh1;
    act[2] = TmdsCh2;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt - 2) begin
      e = sb.pop_front();
      for (int c = 0; c < 3; c++) begin
        check(e.tag, "sym", c, act[c], e.exp[c], e.cyc);
        if (e.dec) begin
          check(e.tag, "decode", c, {2'b00, dec10(act[c])}, {2'b00, e.dat[c]}, e.cyc);
          rd[c] = rd[c] + 2 * $countones(act[c]) - 10;
          checks++;
          if (rd[c] > 10 || rd[c] < -10) begin
            failures++;
            $display("FAIL %0s disparity ch%0d actual=%0d required=within+-10 cyc=%0d",
                     e.tag, c, rd[c], e.cyc);
          end
        end else begin
          rd[c] = 0;
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < 3; c++) cnt_m[c] = 0;

    // Reset held 4 clocks with random inputs, then blanking with no sync.
    for (int i = 0; i < 4; i++)
      go(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), "reset");
    for (int i = 0; i < 3; i++) go(1'b1, 1'b0, 1'b0, 1'b0, 24'($urandom), "rstidle");

    // Control tokens on blue, sweep (VS,HS).
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, "token", 1'b1, 10'h354, 10'h354, 10'h354);
    step(1'b1, 1'b0, 1'b1, 1'b0, 24'h654321, "token", 1'b1, 10'h0AB, 10'h354, 10'h354);
    step(1'b1, 1'b0, 1'b0, 1'b1, 24'hABCDEF, "token", 1'b1, 10'h154, 10'h354, 10'h354);
    step(1'b1, 1'b0, 1'b1, 1'b1, 24'hFEDCBA, "token", 1'b1, 10'h2AB, 10'h354, 10'h354);

    // Black: 0x100 (Cnt -8) then 0x3FF (Cnt +2) on every channel.
    step(1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, "black", 1'b1, 10'h100, 10'h100, 10'h100);
    step(1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, "black", 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    go(1'b1, 1'b0, 1'b0, 1'b0, '0, "blank");

    // Red white, one-cycle blank, red white again: both 0x200.
    step(1'b1, 1'b1, 1'b0, 1'b0, 24'hFF0000, "white", 1'b1, 10'h100, 10'h100, 10'h200);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'hFF0000, "white", 1'b1, 10'h354, 10'h354, 10'h354);
    step(1'b1, 1'b1, 1'b0, 1'b0, 24'hFF0000, "white", 1'b1, 10'h100, 10'h100, 10'h200);
    go(1'b1, 1'b0, 1'b1, 1'b0, '0, "blank");

    // A full 1280-pixel random line against the reference encoder.
    for (int i = 0; i < 1280; i++) go(1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom), "line");
    for (int i = 0; i < 8; i++)
      go(1'b1, 1'b0, 1'($urandom), 1'($urandom), 24'($urandom), "hblank");

    // Reset for one clock in the middle of active video.
    for (int i = 0; i < 100; i++) go(1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom), "line2");
    go(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom), "mreset");
    for (int i = 0; i < 100; i++) go(1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom), "post");
    for (int i = 0; i < 4; i++) go(1'b1, 1'b0, 1'b0, 1'b0, '0, "tail");
    stim_done = 1;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge PixelClk);
    @(negedge PixelClk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
